// File: rtl/add_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_arb_pkg
// Purpose  : Shared definitions for the round-robin adder arbiter.
//            - default operand width and requester count
//            - ID_W, the width of a requester index at the default count
//            - control FSM state encoding
//            - round-robin pointer advance helper
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package add_arb_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int N_REQ_DEF = 4;
  localparam int ID_W      = $clog2(N_REQ_DEF);

  // EMPTY: output register holds nothing; FULL: res_* carry a live result.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

  // Index that follows a granted requester, wrapping at the requester count.
  function automatic int rr_next(input int idx, input int n_req);
    return (idx >= n_req - 1) ? 0 : idx + 1;
  endfunction

endpackage : add_arb_pkg
`default_nettype wire

// File: rtl/add_arbiter_add.sv
`default_nettype none
// ============================================================================
// Module   : add_arbiter_add
// Purpose  : Shared unsigned adder. Produces the full (WIDTH+1)-bit sum so
//            the caller can take the carry from the top bit.
// Ports    : a    - first operand  [WIDTH-1:0]
//            b    - second operand [WIDTH-1:0]
//            sum  - a + b including carry-out [WIDTH:0]
// Revision : 1.0  initial release
// ============================================================================
module add_arbiter_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule : add_arbiter_add
`default_nettype wire

// File: rtl/add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : add_arbiter
// Purpose  : N_REQ requesters share one adder. A combinational round-robin
//            arbiter grants one requester per cycle whenever the single-entry
//            output register is free (or is being drained in that same cycle);
//            the granted sum, carry and signed overflow appear one cycle later.
// Ports    : clock      - single clock, rising edge
//            reset      - synchronous, active-high
//            req_valid  - per-requester request strobe [N_REQ-1:0]
//            req_a/b    - packed operands, requester i at [i*WIDTH +: WIDTH]
//            grant      - one-hot-or-zero acceptance strobe (combinational)
//            res_valid  - result register holds a live result
//            res_ready  - consumer accepts the result this cycle
//            res_id     - index of the requester owning the result
//            res_sum    - sum modulo 2^WIDTH
//            res_carry  - unsigned carry-out
//            res_ovf    - signed two's-complement overflow
// Params   : N_REQ 2..8, WIDTH operand width
// Revision : 1.0  initial release
// ============================================================================
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic [N_REQ-1:0]           grant,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(N_REQ)-1:0]   res_id,
  output logic [WIDTH-1:0]           res_sum,
  output logic                       res_carry,
  output logic                       res_ovf
);

  localparam int C_ID_W = $clog2(N_REQ);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic [C_ID_W-1:0]   r_ptr;
  logic [C_ID_W-1:0]   r_id;
  logic [WIDTH-1:0]    r_sum;
  logic                r_carry;
  logic                r_ovf;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic                w_slot_free;
  logic                w_any;
  logic [C_ID_W-1:0]   w_idx;
  logic                w_grant_en;

  // The held result leaving this cycle frees the slot for a new grant.
  assign w_slot_free = !res_valid || res_ready;

  // Walk the requesters starting at r_ptr. r_ptr < N_REQ, so one subtraction
  // of N_REQ is enough to wrap; C_ID_W+1 bits hold values up to 2*N_REQ-2.
  always_comb begin : p_rr_search
    logic [C_ID_W:0] v_pos;
    w_any = 1'b0;
    w_idx = '0;
    v_pos = '0;
    for (int off = 0; off < N_REQ; off++) begin
      v_pos = {1'b0, r_ptr} + (C_ID_W+1)'(off);
      if (v_pos >= (C_ID_W+1)'(N_REQ)) begin
        v_pos = v_pos - (C_ID_W+1)'(N_REQ);
      end
      if (!w_any && req_valid[v_pos[C_ID_W-1:0]]) begin
        w_any = 1'b1;
        w_idx = v_pos[C_ID_W-1:0];
      end
    end
  end

  // Reset suppresses acceptance so nothing is lost into a discarded result.
  assign w_grant_en = w_any && w_slot_free && !reset;

  always_comb begin : p_grant
    grant = '0;
    if (w_grant_en) begin
      grant[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin : p_ptr
    if (reset) begin
      r_ptr <= '0;
    end else if (w_grant_en) begin
      r_ptr <= C_ID_W'(rr_next(int'(w_idx), N_REQ));
    end
  end

  // --------------------------------------------------------------------------
  // Shared datapath: granted-operand mux feeding the single adder
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_a_arr [N_REQ];
  logic [WIDTH-1:0] w_b_arr [N_REQ];
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign w_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  assign w_a = w_a_arr[w_idx];
  assign w_b = w_b_arr[w_idx];

  add_arbiter_add #(
    .WIDTH (WIDTH)
  ) u_add (
    .a   (w_a),
    .b   (w_b),
    .sum (w_sum)
  );

  // Signed overflow: like-signed operands producing a result of the other sign.
  assign w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

  // Result register loads only on a grant, so it holds steady under
  // backpressure (no grant can issue while FULL and not ready).
  always_ff @(posedge clock) begin : p_result
    if (reset) begin
      r_id    <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_grant_en) begin
      r_id    <= w_idx;
      r_sum   <= w_sum[WIDTH-1:0];
      r_carry <= w_sum[WIDTH];
      r_ovf   <= w_ovf;
    end
  end

  assign res_id    = r_id;
  assign res_sum   = r_sum;
  assign res_carry = r_carry;
  assign res_ovf   = r_ovf;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin : p_state_reg
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin : p_next_state
    w_next_state = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_grant_en) begin
          w_next_state = ST_FULL;
        end
      end
      ST_FULL: begin
        // Drain together with a grant refills the slot and stays FULL.
        if (res_ready && !w_grant_en) begin
          w_next_state = ST_EMPTY;
        end
      end
      default: w_next_state = ST_EMPTY;
    endcase
  end

  always_comb begin : p_state_out
    res_valid = (r_state == ST_FULL);
  end

endmodule : add_arbiter
`default_nettype wire

// File: tb/tb_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_arbiter
// Purpose  : Self-checking bench for add_arbiter (N_REQ=4, WIDTH=32).
//            Directed scenarios followed by a randomized phase, all checked
//            against a round-robin reference model kept in this file.
// Revision : 1.0  initial release
// ============================================================================
module tb_add_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     grant;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [1:0]       res_id;
  logic [W-1:0]     res_sum;
  logic             res_carry;
  logic             res_ovf;

  always #5 clock = ~clock;

  add_arbiter #(
    .N_REQ (N),
    .WIDTH (W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .grant     (grant),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_ovf   (res_ovf)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] a_op [N];
  logic [W-1:0] b_op [N];

  // Reference model state
  int           m_ptr   = 0;
  bit           m_valid = 0;
  int           m_id    = 0;
  logic [W-1:0] m_sum   = '0;
  bit           m_carry = 0;
  bit           m_ovf   = 0;
  logic [N-1:0] last_grant = '0;
  bit           saw_id3 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive inputs, check grant mid-cycle, clock, check result.
  task automatic step(input logic [N-1:0] v, input bit rdy, input bit rst, input string tag);
    logic [N-1:0] eg;
    bit           g;
    int           gi;
    logic [W:0]   s;
    longint       ss;
    req_valid = v;
    res_ready = rdy;
    reset     = rst;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_op[i];
      req_b[i*W +: W] = b_op[i];
    end
    #4;
    eg = '0; g = 0; gi = 0;
    if (!rst && (!m_valid || rdy)) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!g && v[i]) begin
          g = 1; gi = i; eg[i] = 1'b1;
        end
      end
    end
    last_grant = grant;
    chk({tag, ".grant"}, 64'(grant), 64'(eg));
    @(posedge clock);
    #1;
    if (rst) begin
      m_valid = 0; m_ptr = 0; m_id = 0; m_sum = '0; m_carry = 0; m_ovf = 0;
    end else if (g) begin
      s       = {1'b0, a_op[gi]} + {1'b0, b_op[gi]};
      m_sum   = s[W-1:0];
      m_carry = s[W];
      ss      = longint'($signed(a_op[gi])) + longint'($signed(b_op[gi]));
      m_ovf   = (ss > 64'sh7FFFFFFF) || (ss < -64'sh80000000);
      m_valid = 1;
      m_id    = gi;
      m_ptr   = (gi + 1) % N;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    chk({tag, ".res_valid"}, 64'(res_valid), 64'(m_valid));
    if (m_valid || rst) begin
      chk({tag, ".res_id"},    64'(res_id),    64'(m_id));
      chk({tag, ".res_sum"},   64'(res_sum),   64'(m_sum));
      chk({tag, ".res_carry"}, 64'(res_carry), 64'(m_carry));
      chk({tag, ".res_ovf"},   64'(res_ovf),   64'(m_ovf));
    end
    if (res_valid && res_id == 2'd3) saw_id3 = 1;
  endtask

  initial begin
    logic [W-1:0] held;
    for (int i = 0; i < N; i++) begin
      a_op[i] = '0; b_op[i] = '0;
    end
    @(posedge clock);
    #1;

    // Reset: grant forced low, outputs cleared
    step(4'b1111, 1'b1, 1'b1, "rst0");
    step(4'b1111, 1'b0, 1'b1, "rst1");

    // Single request: 5 + 7
    a_op[0] = 32'd5; b_op[0] = 32'd7;
    step(4'b0001, 1'b1, 1'b0, "s030");
    chk("s030.grant_seen", 64'(last_grant), 64'h1);
    chk("s030.sum12", 64'(res_sum), 64'd12);
    step(4'b0000, 1'b1, 1'b0, "s030_drain");

    // All requesting, consumer always ready: rotating grants, back-to-back results
    step(4'b0000, 1'b1, 1'b1, "s031_rst");
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) begin
        a_op[i] = $urandom; b_op[i] = $urandom;
      end
      step(4'b1111, 1'b1, 1'b0, "s031");
      chk("s031.rot", 64'(last_grant), 64'(4'b0001 << (k % N)));
      chk("s031.hold_valid", 64'(res_valid), 64'd1);
    end

    // Carry / overflow corners
    step(4'b0000, 1'b1, 1'b1, "s032_rst");
    a_op[0] = 32'h7FFF_FFFF; b_op[0] = 32'h0000_0001;
    a_op[1] = 32'hFFFF_FFFF; b_op[1] = 32'h0000_0001;
    a_op[2] = 32'h8000_0000; b_op[2] = 32'h8000_0000;
    step(4'b0001, 1'b1, 1'b0, "s032_ovf");
    chk("s032.ovf_sum", 64'(res_sum), 64'h8000_0000);
    chk("s032.ovf_bit", 64'(res_ovf), 64'd1);
    step(4'b0010, 1'b1, 1'b0, "s032_carry");
    chk("s032.carry_sum", 64'(res_sum), 64'h0);
    chk("s032.carry_bit", 64'(res_carry), 64'd1);
    step(4'b0100, 1'b1, 1'b0, "s032_both");

    // Backpressure: three stalled cycles, then release
    step(4'b0000, 1'b1, 1'b1, "s033_rst");
    a_op[0] = $urandom; b_op[0] = $urandom;
    a_op[1] = $urandom; b_op[1] = $urandom;
    a_op[2] = $urandom; b_op[2] = $urandom;
    step(4'b0001, 1'b0, 1'b0, "s033_load");
    held = res_sum;
    for (int k = 0; k < 3; k++) begin
      step(4'b0110, 1'b0, 1'b0, "s033_stall");
      chk("s033.no_grant", 64'(last_grant), 64'h0);
      chk("s033.stable", 64'(res_sum), 64'(held));
    end
    step(4'b0110, 1'b1, 1'b0, "s033_release");
    chk("s033.grant1", 64'(last_grant), 64'h2);
    chk("s033.id1", 64'(res_id), 64'd1);

    // Reset with a live result and ptr=2
    step(4'b0000, 1'b0, 1'b1, "s034_rst");
    chk("s034.cleared", 64'(res_valid), 64'd0);
    step(4'b1111, 1'b1, 1'b0, "s034_after");
    chk("s034.grant0", 64'(last_grant), 64'h1);

    // Requester 3 withdraws while the slot is blocked
    saw_id3 = 0;
    step(4'b1000, 1'b0, 1'b0, "s035_blk");
    step(4'b1000, 1'b0, 1'b0, "s035_blk");
    step(4'b0000, 1'b0, 1'b0, "s035_drop");
    step(4'b0011, 1'b1, 1'b0, "s035_other");
    step(4'b0011, 1'b1, 1'b0, "s035_other");
    step(4'b0000, 1'b1, 1'b0, "s035_drain");
    chk("s035.no_id3", 64'(saw_id3), 64'd0);

    // Randomized traffic with occasional corner operands and resets
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0:       begin a_op[i] = 32'hFFFF_FFFF; b_op[i] = $urandom; end
          1:       begin a_op[i] = 32'h7FFF_FFFF; b_op[i] = $urandom_range(0, 3); end
          2:       begin a_op[i] = 32'h8000_0000; b_op[i] = 32'h8000_0000 | $urandom; end
          default: begin a_op[i] = $urandom; b_op[i] = $urandom; end
        endcase
      end
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_add_arbiter
`default_nettype wire
